// File: rtl/hud_pkg.sv
// Shared HUD definitions: game states, BCD digit type and score glyph placement
// used by both the score sequencer and the digit renderer.
package hud_pkg;

    typedef enum logic [1:0] {
        MENU = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam int NUM_SCORE_DIGITS = 4;

    // Score glyph placement, X measured from the game-view left border.
    localparam int SCORE_Y_ORIGIN = 22;
    localparam int DIGIT_WIDTH    = 13;
    localparam int DIGIT_HEIGHT   = 12;
    localparam int DIGIT_GAP      = 2;
    localparam int SCORE_X_OFFSET = 266;

    localparam logic [1:0] SEQ_IDLE = 2'd0;
    localparam logic [1:0] SEQ_INC  = 2'd1;
    localparam logic [1:0] SEQ_CMP  = 2'd2;

    function automatic logic bcd_is_nine(input bcd_digit_t digit);
        return digit >= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_incr.sv
// Combinational single-digit BCD increment with carry-out; one instance is
// shared by every step of the score carry ripple.
module bcd_digit_incr
    import hud_pkg::*;
(
    input  bcd_digit_t digit_in,
    output bcd_digit_t digit_out,
    output logic       carry_out
);

    always_comb begin
        if (bcd_is_nine(digit_in)) begin
            digit_out = 4'd0;
            carry_out = 1'b1;
        end else begin
            digit_out = digit_in + 4'd1;
            carry_out = 1'b0;
        end
    end

endmodule

// File: rtl/score_sequencer.sv
// BCD game score with per-jump collision cooldown and a one-digit-per-clock
// carry ripple. Define SCORE_BEST_EN to add the session-best register.
module score_sequencer
    import hud_pkg::*;
#(
    parameter int NUM_DIGITS      = NUM_SCORE_DIGITS,
    parameter int COOLDOWN_FRAMES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    calculation_time,
    input  logic [1:0]              game_state,
    input  logic                    move_collision,
    output logic [NUM_DIGITS*4-1:0] score_bcd,
    output logic                    score_busy,
    output logic                    score_saturated,
    output logic [NUM_DIGITS*4-1:0] best_bcd,
    output logic                    new_best
);

    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = NUM_DIGITS * 4;
    localparam logic [SW-1:0] ALL_NINES  = {NUM_DIGITS{4'd9}};
    localparam logic [CW-1:0] COOL_LOAD  = CW'(COOLDOWN_FRAMES - 1);
    localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] digit_idx_q, digit_idx_d;
    logic [SW-1:0] score_q, score_d;
    logic [CW-1:0] cooldown_q, cooldown_d;
    logic          pending_q, pending_d;
    logic [1:0]    prev_state_q, prev_state_d;

    logic          session_start;
    logic          frame_in_play;
    logic          request;
    logic          cmp_req;
    bcd_digit_t    cur_digit;
    bcd_digit_t    inc_digit;
    logic          inc_carry;

    assign session_start   = (game_state == PLAY) && (prev_state_q != PLAY);
    assign frame_in_play   = calculation_time && (game_state == PLAY);
    assign score_saturated = (score_q == ALL_NINES);
    assign request         = frame_in_play && move_collision && (cooldown_q == '0)
                             && !score_saturated && !session_start;
    assign cur_digit       = score_q[int'(digit_idx_q)*4 +: 4];

    bcd_digit_incr u_digit_incr (
        .digit_in  (cur_digit),
        .digit_out (inc_digit),
        .carry_out (inc_carry)
    );

`ifdef SCORE_BEST_EN
    logic [SW-1:0] best_q, best_d;
    logic          new_best_q, new_best_d;
    logic          over_pending_q, over_pending_d;
    logic          over_edge;

    // Game-over entry is remembered until any running ripple has settled.
    assign over_edge = (game_state == OVER) && (prev_state_q != OVER);
    assign cmp_req   = over_edge || over_pending_q;
    assign best_bcd  = best_q;
    assign new_best  = new_best_q;
`else
    assign cmp_req   = 1'b0;
    assign best_bcd  = '0;
    assign new_best  = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        digit_idx_d  = digit_idx_q;
        score_d      = score_q;
        cooldown_d   = cooldown_q;
        pending_d    = pending_q;
        prev_state_d = game_state;
`ifdef SCORE_BEST_EN
        best_d         = best_q;
        new_best_d     = new_best_q;
        over_pending_d = over_pending_q;
`endif

        if (request) begin
            cooldown_d = COOL_LOAD;
        end else if (frame_in_play && score_saturated) begin
            cooldown_d = '0;
        end else if (frame_in_play && (cooldown_q != '0)) begin
            cooldown_d = cooldown_q - 1'b1;
        end

        case (state_q)
            SEQ_IDLE: begin
                pending_d = 1'b0;
                if ((request || pending_q) && !score_saturated) begin
                    state_d     = SEQ_INC;
                    digit_idx_d = '0;
                end else if (cmp_req) begin
                    state_d = SEQ_CMP;
                end
            end
            SEQ_INC: begin
                if (request) begin
                    pending_d = 1'b1;
                end
                // A carry out of the top digit would wrap all-nines, so it is held instead.
                if (inc_carry && (digit_idx_q != LAST_DIGIT)) begin
                    score_d[int'(digit_idx_q)*4 +: 4] = inc_digit;
                    digit_idx_d = digit_idx_q + 1'b1;
                end else begin
                    if (!inc_carry) begin
                        score_d[int'(digit_idx_q)*4 +: 4] = inc_digit;
                    end
                    state_d = cmp_req ? SEQ_CMP : SEQ_IDLE;
                end
            end
`ifdef SCORE_BEST_EN
            SEQ_CMP: begin
                state_d = SEQ_IDLE;
                // Valid BCD orders like plain binary, most significant digit first.
                if (score_q > best_q) begin
                    best_d     = score_q;
                    new_best_d = 1'b1;
                end
            end
`endif
            default: state_d = SEQ_IDLE;
        endcase

`ifdef SCORE_BEST_EN
        if (state_d == SEQ_CMP) begin
            over_pending_d = 1'b0;
        end else if (over_edge) begin
            over_pending_d = 1'b1;
        end
`endif

        if (session_start) begin
            state_d     = SEQ_IDLE;
            digit_idx_d = '0;
            score_d     = '0;
            cooldown_d  = '0;
            pending_d   = 1'b0;
`ifdef SCORE_BEST_EN
            best_d         = best_q;
            new_best_d     = 1'b0;
            over_pending_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SEQ_IDLE;
            digit_idx_q  <= '0;
            score_q      <= '0;
            cooldown_q   <= '0;
            pending_q    <= 1'b0;
            prev_state_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            digit_idx_q  <= digit_idx_d;
            score_q      <= score_d;
            cooldown_q   <= cooldown_d;
            pending_q    <= pending_d;
            prev_state_q <= prev_state_d;
        end
    end

`ifdef SCORE_BEST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            best_q         <= '0;
            new_best_q     <= 1'b0;
            over_pending_q <= 1'b0;
        end else begin
            best_q         <= best_d;
            new_best_q     <= new_best_d;
            over_pending_q <= over_pending_d;
        end
    end
`endif

    assign score_bcd  = score_q;
    assign score_busy = (state_q == SEQ_INC);

endmodule

// File: tb/tb_score_sequencer.sv
// Scoreboard bench for score_sequencer: a 4-digit and a 2-digit instance share
// one randomized stimulus stream and are checked against a decimal score model.
module tb_score_sequencer;

    localparam int CF = 16;

    typedef struct {
        int value;
        int cycles;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        calculation_time = 1'b0;
    logic [1:0]  game_state = 2'd0;
    logic        move_collision = 1'b0;

    logic [15:0] a_score, a_best;
    logic        a_busy, a_sat, a_nb;
    logic [7:0]  b_score, b_best;
    logic        b_busy, b_sat, b_nb;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = 4-digit instance, 1 = 2-digit instance.
    int   m_score[2];
    int   m_cool[2];
    int   m_best[2];
    bit   m_nb[2];
    int   m_max[2];
    int   m_prev_gs;
    exp_t qa[$];
    exp_t qb[$];

    int   busy_cnt[2];
    logic busy_prev[2];
    logic [1:0] mon_prev_gs;

    always #5 clk = ~clk;

    score_sequencer dut_a (
        .clk              (clk),
        .rst              (rst),
        .calculation_time (calculation_time),
        .game_state       (game_state),
        .move_collision   (move_collision),
        .score_bcd        (a_score),
        .score_busy       (a_busy),
        .score_saturated  (a_sat),
        .best_bcd         (a_best),
        .new_best         (a_nb)
    );

    score_sequencer #(.NUM_DIGITS(2), .COOLDOWN_FRAMES(CF)) dut_b (
        .clk              (clk),
        .rst              (rst),
        .calculation_time (calculation_time),
        .game_state       (game_state),
        .move_collision   (move_collision),
        .score_bcd        (b_score),
        .score_busy       (b_busy),
        .score_saturated  (b_sat),
        .best_bcd         (b_best),
        .new_best         (b_nb)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int ripple_len(input int v);
        int n;
        int t;
        n = 1;
        t = v;
        while (t % 10 == 9) begin
            n++;
            t = t / 10;
        end
        return n;
    endfunction

    function automatic int exp_best(input int i);
`ifdef SCORE_BEST_EN
        return m_best[i];
`else
        return 0 * i;
`endif
    endfunction

    function automatic int exp_nb(input int i);
`ifdef SCORE_BEST_EN
        return int'(m_nb[i]);
`else
        return 0 * i;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Advances the model by the clock edge that will sample the given inputs.
    task automatic model_step(input bit r, input bit calc, input logic [1:0] gs, input bit coll);
        bit   sess;
        bit   over_edge;
        exp_t e;
        if (r) begin
            for (int i = 0; i < 2; i++) begin
                m_score[i] = 0;
                m_cool[i]  = 0;
                m_best[i]  = 0;
                m_nb[i]    = 0;
            end
            qa.delete();
            qb.delete();
            m_prev_gs = 0;
            return;
        end
        sess      = (gs == 2'd1) && (m_prev_gs != 1);
        over_edge = (gs == 2'd2) && (m_prev_gs != 2);
        for (int i = 0; i < 2; i++) begin
            if (sess) begin
                m_score[i] = 0;
                m_cool[i]  = 0;
                m_nb[i]    = 0;
                if (i == 0) qa.delete(); else qb.delete();
            end else if (calc && gs == 2'd1) begin
                if (m_score[i] == m_max[i]) begin
                    m_cool[i] = 0;
                end else if (coll && m_cool[i] == 0) begin
                    e.value  = m_score[i] + 1;
                    e.cycles = ripple_len(m_score[i]);
                    if (i == 0) qa.push_back(e); else qb.push_back(e);
                    m_score[i] = m_score[i] + 1;
                    m_cool[i]  = CF - 1;
                end else if (m_cool[i] > 0) begin
                    m_cool[i] = m_cool[i] - 1;
                end
            end
            if (over_edge && m_score[i] > m_best[i]) begin
                m_best[i] = m_score[i];
                m_nb[i]   = 1;
            end
        end
        m_prev_gs = int'(gs);
    endtask

    task automatic applyStimulus(input bit r, input bit calc, input logic [1:0] gs, input bit coll);
        @(negedge clk);
        rst              = r;
        calculation_time = calc;
        game_state       = gs;
        move_collision   = coll;
        model_step(r, calc, gs, coll);
    endtask

    task automatic checkOutput(input string tag);
        @(posedge clk);
        #1;
        check({tag, "/a_score"}, 32'(a_score), 32'(to_bcd(m_score[0])));
        check({tag, "/a_busy"},  32'(a_busy),  32'd0);
        check({tag, "/a_sat"},   32'(a_sat),   32'(m_score[0] == m_max[0]));
        check({tag, "/a_best"},  32'(a_best),  32'(to_bcd(exp_best(0))));
        check({tag, "/a_nb"},    32'(a_nb),    32'(exp_nb(0)));
        check({tag, "/b_score"}, 32'(b_score), 32'(to_bcd(m_score[1])));
        check({tag, "/b_busy"},  32'(b_busy),  32'd0);
        check({tag, "/b_sat"},   32'(b_sat),   32'(m_score[1] == m_max[1]));
        check({tag, "/b_best"},  32'(b_best),  32'(to_bcd(exp_best(1))));
        check({tag, "/b_nb"},    32'(b_nb),    32'(exp_nb(1)));
    endtask

    task automatic idle(input int n, input logic [1:0] gs);
        repeat (n) applyStimulus(0, 0, gs, 0);
    endtask

    task automatic playUntil(input int target, input bit randomize_it);
        int  guard;
        bit  calc;
        bit  coll;
        guard = 0;
        while (m_score[0] < target && guard < 40000) begin
            calc = randomize_it ? ($urandom_range(0, 3) != 0) : 1'b1;
            coll = randomize_it ? ($urandom_range(0, 7) != 0) : 1'b1;
            applyStimulus(0, calc, 2'd1, coll);
            guard++;
        end
        if (guard >= 40000) begin
            checks++;
            errors++;
            $display("[TB] FAIL play_timeout actual=%0d required=%0d", m_score[0], target);
        end
    endtask

    task automatic waitCooldown();
        int guard;
        guard = 0;
        while (m_cool[0] != 0 && guard < 64) begin
            applyStimulus(0, 1, 2'd1, 0);
            guard++;
        end
    endtask

    task automatic monitor_one(input int idx, input logic busy, input logic [15:0] score, input bit sess);
        exp_t e;
        if (busy === 1'b1) begin
            busy_cnt[idx]++;
        end else if (busy_prev[idx] === 1'b1) begin
            if (!sess) begin
                if ((idx == 0 && qa.size() == 0) || (idx == 1 && qb.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_incr inst=%0d actual=%0h required=none", idx, score);
                end else begin
                    e = (idx == 0) ? qa.pop_front() : qb.pop_front();
                    check($sformatf("incr_value%0d", idx), 32'(score), 32'(to_bcd(e.value)));
                    check($sformatf("busy_len%0d", idx), 32'(busy_cnt[idx]), 32'(e.cycles));
                end
            end
            busy_cnt[idx] = 0;
        end
        busy_prev[idx] = busy;
    endtask

    // Monitor: consumes one expected score each time a ripple completes.
    initial begin
        logic       r_s;
        logic [1:0] gs_s;
        bit         sess;
        busy_cnt[0] = 0;
        busy_cnt[1] = 0;
        busy_prev[0] = 1'b0;
        busy_prev[1] = 1'b0;
        mon_prev_gs = 2'd0;
        forever begin
            @(posedge clk);
            r_s  = rst;
            gs_s = game_state;
            sess = r_s || (gs_s == 2'd1 && mon_prev_gs != 2'd1);
            mon_prev_gs = r_s ? 2'd0 : gs_s;
            #1;
            monitor_one(0, a_busy, a_score, sess);
            monitor_one(1, b_busy, {8'h00, b_score}, sess);
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int targets[3];
        m_max[0] = 9999;
        m_max[1] = 99;
        targets[0] = 12;
        targets[1] = 7;
        targets[2] = 20;

        applyStimulus(1, 0, 2'd0, 0);
        applyStimulus(1, 0, 2'd0, 0);
        checkOutput("reset");

        $display("[TB] session start, collision held for 40 frames");
        applyStimulus(0, 0, 2'd0, 0);
        applyStimulus(0, 0, 2'd1, 0);
        for (int f = 0; f < 40; f++) begin
            applyStimulus(0, 1, 2'd1, 1);
            applyStimulus(0, 0, 2'd1, 1);
        end
        idle(4, 2'd1);
        checkOutput("cooldown40");
        check("three_incr", 32'(a_score), 32'h0003);

        $display("[TB] random play up to 0999");
        playUntil(999, 1'b1);
        idle(8, 2'd1);
        checkOutput("preload999");
        check("sat_cooldown", 32'(dut_b.cooldown_q), 32'd0);

        waitCooldown();
        applyStimulus(0, 1, 2'd1, 1);
        idle(8, 2'd1);
        checkOutput("carry1000");
        check("score1000", 32'(a_score), 32'h1000);
        check("sat_score99", 32'(b_score), 32'h99);
        check("sat_cooldown2", 32'(dut_b.cooldown_q), 32'd0);

        $display("[TB] collisions outside frames and outside play");
        repeat (5) applyStimulus(0, 0, 2'd1, 1);
        repeat (5) begin
            applyStimulus(0, 1, 2'd2, 1);
            applyStimulus(0, 0, 2'd2, 1);
        end
        repeat (3) applyStimulus(0, 1, 2'd3, 1);
        idle(4, 2'd3);
        checkOutput("ignored");
        check("hold_cooldown", 32'(dut_a.cooldown_q), 32'(m_cool[0]));

        $display("[TB] ripple interrupted by a new session");
        applyStimulus(0, 0, 2'd0, 0);
        applyStimulus(0, 0, 2'd1, 0);
        playUntil(99, 1'b0);
        idle(6, 2'd1);
        waitCooldown();
        applyStimulus(0, 1, 2'd1, 1);
        applyStimulus(0, 0, 2'd2, 0);
        applyStimulus(0, 0, 2'd1, 0);
        checkOutput("abort");
        idle(4, 2'd1);

        $display("[TB] session best tracking");
        applyStimulus(1, 0, 2'd0, 0);
        applyStimulus(1, 0, 2'd0, 0);
        checkOutput("reset2");
        for (int s = 0; s < 3; s++) begin
            applyStimulus(0, 0, 2'd0, 0);
            applyStimulus(0, 0, 2'd1, 0);
            playUntil(targets[s], 1'b0);
            idle(6, 2'd2);
            checkOutput($sformatf("session%0d", s));
        end

        check("queue_a_drained", 32'(qa.size()), 32'd0);
        check("queue_b_drained", 32'(qb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
